// File: rtl/player_mover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : player_mover                                                     |
// | Purpose : Position engine for the four-player paint game. Latches each     |
// |           player's heading from its direction request and, once every      |
// |           TICK_DIV running cycles, moves all four players one pixel,       |
// |           wrapping at the screen edges.                                    |
// | Ports   : CLOCK_50      - clock, rising edge                               |
// |           reset         - asynchronous active-high reset                   |
// |           running       - enable; low freezes divider/headings/positions   |
// |           p1d..p4d [2:0]- direction request (001 up, 010 down,             |
// |                           011 left, 100 right, others ignored)             |
// |           p1..p4  [14:0]- registered positions {x[7:0], y[6:0]}            |
// |           step          - one-cycle pulse when new positions are visible   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module player_mover #(
  parameter int TICK_DIV = 2_500_000,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        running,
  input  logic [2:0]  p1d,
  input  logic [2:0]  p2d,
  input  logic [2:0]  p3d,
  input  logic [2:0]  p4d,
  output logic [14:0] p1,
  output logic [14:0] p2,
  output logic [14:0] p3,
  output logic [14:0] p4,
  output logic        step
);

  localparam logic [2:0] c_DIR_UP    = 3'b001;
  localparam logic [2:0] c_DIR_DOWN  = 3'b010;
  localparam logic [2:0] c_DIR_LEFT  = 3'b011;
  localparam logic [2:0] c_DIR_RIGHT = 3'b100;

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [7:0] c_X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] c_Y_MAX = 7'(SCREEN_H - 1);

  // Start positions and headings, player 1 in the lowest slice.
  localparam logic [4*15-1:0] c_POS_RST = {15'h45E3, 15'h0A63, 15'h4594, 15'h0A14};
  localparam logic [4*3-1:0]  c_HDG_RST = {c_DIR_LEFT, c_DIR_RIGHT, c_DIR_LEFT, c_DIR_RIGHT};

  logic [DIV_W-1:0] r_div;
  logic             r_step;
  logic             w_step_edge;
  logic [2:0]       w_req [4];
  logic [14:0]      w_pos [4];

  assign w_req[0] = p1d;
  assign w_req[1] = p2d;
  assign w_req[2] = p3d;
  assign w_req[3] = p4d;

  assign w_step_edge = running && (r_div == c_DIV_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_step_edge;
      if (running) begin
        r_div <= w_step_edge ? '0 : r_div + DIV_W'(1);
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_player
    logic [2:0] r_hdg;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [7:0] w_nx;
    logic [6:0] w_ny;
    logic       w_valid;
    logic       w_reverse;

    assign w_valid = (w_req[i] >= c_DIR_UP) && (w_req[i] <= c_DIR_RIGHT);

    assign w_reverse = ((w_req[i] == c_DIR_UP)    && (r_hdg == c_DIR_DOWN))  ||
                       ((w_req[i] == c_DIR_DOWN)  && (r_hdg == c_DIR_UP))    ||
                       ((w_req[i] == c_DIR_LEFT)  && (r_hdg == c_DIR_RIGHT)) ||
                       ((w_req[i] == c_DIR_RIGHT) && (r_hdg == c_DIR_LEFT));

    // Wrap is decided before the add/subtract so no off-screen value can appear.
    always_comb begin
      w_nx = r_x;
      w_ny = r_y;
      case (r_hdg)
        c_DIR_RIGHT: w_nx = (r_x == c_X_MAX) ? 8'd0 : r_x + 8'd1;
        c_DIR_LEFT:  w_nx = (r_x == 8'd0) ? c_X_MAX : r_x - 8'd1;
        c_DIR_DOWN:  w_ny = (r_y == c_Y_MAX) ? 7'd0 : r_y + 7'd1;
        c_DIR_UP:    w_ny = (r_y == 7'd0) ? c_Y_MAX : r_y - 7'd1;
        default: ;
      endcase
    end

    // Position uses the heading held before this edge; a request arriving on
    // a step edge therefore only affects the following step.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        r_hdg <= c_HDG_RST[i*3 +: 3];
        r_x   <= c_POS_RST[i*15+7 +: 8];
        r_y   <= c_POS_RST[i*15 +: 7];
      end else if (running) begin
        if (w_valid && !w_reverse) begin
          r_hdg <= w_req[i];
        end
        if (w_step_edge) begin
          r_x <= w_nx;
          r_y <= w_ny;
        end
      end
    end

    assign w_pos[i] = {r_x, r_y};
  end

  assign p1   = w_pos[0];
  assign p2   = w_pos[1];
  assign p3   = w_pos[2];
  assign p4   = w_pos[3];
  assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_player_mover                                                  |
// | Purpose : Self-checking bench for player_mover against a behavioural       |
// |           model of player positions, headings and tick timing.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_player_mover;

  localparam int TICK_DIV = 4;
  localparam int W = 160;
  localparam int H = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running = 1'b1;
  logic [2:0]  req [4];
  logic [14:0] p1, p2, p3, p4;
  logic        step;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int mx [4];
  int my [4];
  int mh [4];
  int mcnt;
  int mstep;

  bit saw_x0, saw_y119;

  always #5 clk = ~clk;

  player_mover #(.TICK_DIV(TICK_DIV), .SCREEN_W(W), .SCREEN_H(H)) u_dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .running  (running),
    .p1d      (req[0]),
    .p2d      (req[1]),
    .p3d      (req[2]),
    .p4d      (req[3]),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .step     (step)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] dut_pos(input int i);
    case (i)
      0: return p1;
      1: return p2;
      2: return p3;
      default: return p4;
    endcase
  endfunction

  // 1 up, 2 down, 3 left, 4 right
  function automatic int opposite(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mx = '{20, 139, 20, 139};
    my = '{20, 20, 99, 99};
    mh = '{4, 3, 4, 3};
    mcnt = 0;
    mstep = 0;
  endtask

  // One clock edge of the game rules, using inputs as seen before the edge.
  task automatic model_edge();
    bit tick;
    if (rst) begin
      model_reset();
      return;
    end
    tick = running && (mcnt == TICK_DIV - 1);
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        case (mh[i])
          4: mx[i] = (mx[i] + 1) % W;
          3: mx[i] = (mx[i] + W - 1) % W;
          2: my[i] = (my[i] + 1) % H;
          1: my[i] = (my[i] + H - 1) % H;
          default: ;
        endcase
      end
    end
    if (running) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] >= 1 && req[i] <= 4 && int'(req[i]) != opposite(mh[i]))
          mh[i] = int'(req[i]);
      end
      mcnt = tick ? 0 : mcnt + 1;
    end
    mstep = tick;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      logic [14:0] p;
      p = dut_pos(i);
      check($sformatf("pos_p%0d", i + 1), {17'd0, p}, mx[i] * 128 + my[i]);
      check($sformatf("range_p%0d", i + 1), {31'd0, (p[14:7] < W) && (p[6:0] < H)}, 1);
    end
    check("step", {31'd0, step}, mstep);
    if (p1[14:7] == 8'd0)   saw_x0 = 1'b1;
    if (p1[6:0] == 7'd119)  saw_y119 = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_reqs(input int a, input int b, input int c, input int d);
    req[0] = 3'(a); req[1] = 3'(b); req[2] = 3'(c); req[3] = 3'(d);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_p1"}, {17'd0, p1}, 32'h0A14);
    check({tag, "_p2"}, {17'd0, p2}, 32'h4594);
    check({tag, "_p3"}, {17'd0, p3}, 32'h0A63);
    check({tag, "_p4"}, {17'd0, p4}, 32'h45E3);
    check({tag, "_step"}, {31'd0, step}, 0);
  endtask

  initial begin
    int n, x0;
    set_reqs(0, 0, 0, 0);
    model_reset();
    saw_x0 = 0;
    saw_y119 = 0;

    // Reset held with running high
    repeat (3) cycle();
    check_reset_vals("rst");

    // First step at edge TICK_DIV after release
    rst = 1'b0;
    for (int k = 1; k <= TICK_DIV; k++) cycle();
    check("first_p1", {17'd0, p1}, 32'h0A94);
    check("first_p2", {17'd0, p2}, 32'h4514);
    check("first_step", {31'd0, step}, 1);
    cycle();
    check("step_pulse_low", {31'd0, step}, 0);
    repeat (3) cycle();
    check("second_p1_x", {24'd0, p1[14:7]}, 22);

    // Right-wrap then up-wrap on player 1
    set_reqs(4, 0, 0, 0);
    repeat (140 * TICK_DIV) cycle();
    set_reqs(1, 0, 0, 0);
    repeat (30 * TICK_DIV) cycle();
    set_reqs(0, 0, 0, 0);
    check("saw_x_wrap", {31'd0, saw_x0}, 1);
    check("saw_y_wrap", {31'd0, saw_y119}, 1);

    // Reversal rejection on player 2 (heading left)
    x0 = p2[14:7];
    set_reqs(0, 4, 0, 0);
    repeat (3 * TICK_DIV) cycle();
    check("rev_p2_x", {24'd0, p2[14:7]}, (x0 + W - 3) % W);
    set_reqs(0, 1, 0, 0);
    repeat (TICK_DIV) cycle();
    set_reqs(0, 2, 0, 0);
    repeat (4 * TICK_DIV) cycle();
    set_reqs(0, 0, 0, 0);

    // Request on a step edge affects only the following step
    n = 0;
    while (mcnt != TICK_DIV - 1 && n < 10) begin cycle(); n++; end
    check("align_step_edge", mcnt, TICK_DIV - 1);
    set_reqs(0, 0, 2, 0);
    repeat (2 * TICK_DIV) cycle();
    set_reqs(0, 0, 0, 0);

    // Pause at divider == 2
    n = 0;
    while (mcnt != 2 && n < 10) begin cycle(); n++; end
    check("align_pause", mcnt, 2);
    running = 1'b0;
    for (int k = 0; k < 50; k++) begin
      set_reqs($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
      cycle();
    end
    set_reqs(0, 0, 0, 0);
    running = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!step && n < 20);
    check("pause_resume_edges", n, 2);

    // Asynchronous reset between edges after 10 steps
    for (int k = 0; k < 10 * TICK_DIV; k++) begin
      set_reqs($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
      cycle();
    end
    set_reqs(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals("async_rst");
    #1 rst = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (!step && n < 20);
    check("post_rst_edges", n, TICK_DIV);

    // Randomised run
    for (int k = 0; k < 3000; k++) begin
      running = ($urandom_range(9) != 0);
      set_reqs($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_mover.md
# player_mover

Position engine for the four-player paint game: registers each player's heading from the keyboard direction decoder and advances all four 15-bit positions by one pixel on every game tick, wrapping at the 160x120 screen edges. Sits directly upstream of the plotting datapath and of the RAM write path. Both consume `p1`..`p4` as `{x[7:0], y[6:0]}`. Contains its own tick divider and replaces the separate rate divider plus `move` pair.

## Interface
- `TICK_DIV`, default 2_500_000: CLOCK_50 cycles per movement step, minimum 2.
- `SCREEN_W`, default 160: x range 0..SCREEN_W-1.
- `SCREEN_H`, default 120: y range 0..SCREEN_H-1.

Ports:
- `CLOCK_50`  in  1: the single clock, all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `running`  in  1: game enable (SW[0]); low freezes the divider, headings and positions.
- `p1d`, `p2d`, `p3d`, `p4d`  in  3 each: direction requests. Encoding: 3'b001 up, 3'b010 down, 3'b011 left, 3'b100 right; any other value is no request.
- `p1`, `p2`, `p3`, `p4`  out  15 each: registered positions, `[14:7]` is x and `[6:0]` is y.
- `step`  out  1: registered, high for exactly one cycle when the positions have just changed.

## Operation
- Reset values:
  - p1 = (20,20) = 15'h0A14; p2 = (139,20) = 15'h4594; p3 = (20,99) = 15'h0A63; p4 = (139,99) = 15'h45E3.
  - Headings: p1 right, p2 left, p3 right, p4 left.
  - Divider = 0; step = 0.
- Heading register, per player, 3 bits, same encoding as the request inputs:
  - Updated on an edge where running=1 and the request is valid (001..100).
  - A request that is the exact reverse of the current heading is ignored (up/down, left/right). Re-requesting the current heading causes no change.
  - A request held across many cycles is harmless because the update is idempotent.
- Divider:
  - Counts 0..TICK_DIV-1 while running=1; holds its value while running=0.
  - The step edge is the edge at which the divider equals TICK_DIV-1 and running=1. The divider returns to 0 on that edge.
- Step update, for each player, uses the heading value held *before* the edge:
  - Right: x = (x==SCREEN_W-1) ? 0 : x+1.
  - Left: x = (x==0) ? SCREEN_W-1 : x-1.
  - Down: y = (y==SCREEN_H-1) ? 0 : y+1.
  - Up: y = (y==0) ? SCREEN_H-1 : y-1.
  - The unaffected coordinate holds.
- Arithmetic is unsigned and width-exact (x 8-bit, y 7-bit). Wrap detection uses compare-before-increment, so no value outside the screen ever appears on the outputs.
- Players are independent: several players on the same pixel is legal and is not detected here.
- `step` = 1 on the cycle following a step edge, 0 otherwise.

## Timing
- Request to heading: 1 edge.
- A request sampled on a step edge affects the *next* step, not the current one.
- Positions change only on step edges, at most once per TICK_DIV cycles. With running held high, the first step after reset occurs at edge TICK_DIV.
- `step` rises in the same cycle that the new positions are visible. Downstream samples on `step`.
- Deasserting running mid-count freezes the divider. On re-assert, counting resumes where it stopped, so no step is lost or duplicated.
- Reset asserted mid-run, including on a step edge, forces all reset values asynchronously. The first step after release again takes TICK_DIV running edges.

## Test plan
Bench uses TICK_DIV=4.
- Reset check: assert reset, hold running=1 -> outputs read 0A14/4594/0A63/45E3 and step=0. After release with no requests, the first step at edge 4 gives p1=(21,20)=15'h0A94, p2=(138,20)=15'h4514, and step is a one-cycle pulse. After 3 more cycles with no step, the next step gives p1=(22,20).
- Wrap check: set p1d=100 (right) and run p1 from x=20 for 140 steps. The step after x=159 gives x=0. Then set p1d=001 (up) from y=20; the step after y=0 gives y=119. Confirm the outputs never exceed 159/119.
- Reversal rejection: with p2 heading left, drive p2d=100 (right) -> heading unchanged and x keeps decreasing. Drive p2d=001 (up), then p2d=010 (down) -> y decreases on every step (down rejected).
- Step-edge request: change p3d to 010 (down) exactly on a step edge. That step still moves right by 1. The following step moves down by 1.
- Pause: drop running at divider=2 for 50 cycles -> positions frozen, step=0, headings ignore requests. Raise running -> the next step comes exactly 2 running edges later.
- Reset mid-run: assert reset asynchronously between edges after 10 steps -> outputs return to the reset values within the same cycle. The first step after release comes 4 edges later.
